// File: rtl/div4_seq_pkg.sv
// Shared types and constants for the sequential divider and its ALU users.
package div4_seq_pkg;

  localparam int unsigned DIV_WIDTH = 4;

  // Quotient reported on a divide by zero.
  localparam logic [DIV_WIDTH-1:0] DIV_ONES = {DIV_WIDTH{1'b1}};

  // ALU opcodes served by this unit.
  localparam logic [3:0] OP_DIV = 4'hC;
  localparam logic [3:0] OP_MOD = 4'hD;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } div_state_e;

endpackage

// File: rtl/div4_seq_if.sv
// Request/result bundle between the control unit (master) and the divider (slave).
interface div4_seq_if
  import div4_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/full_adder1.sv
// One-bit full adder cell used by the ripple subtractor.
module full_adder1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/sub_borrow.sv
// Ripple subtractor: a - b as a + ~b + 1; the final carry is high when no borrow occurs.
module sub_borrow #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             no_borrow
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] b_inv;

  assign carry[0]  = 1'b1;
  assign b_inv     = ~b;
  assign no_borrow = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder1 u_fa (
      .a    (a[i]),
      .b    (b_inv[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end
endmodule

// File: rtl/div4_seq.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock.
module div4_seq
  import div4_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input logic      clk,
  input logic      rst_n,
  div4_seq_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  div_state_e       state;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   p_reg;
  logic [CW-1:0]    count;
  // Divide-by-zero result is published one edge after acceptance.
  logic             dz_pend;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             no_borrow;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] q_next;
  // The restored/subtracted remainder always fits in WIDTH bits.
  logic             unused_p_msb;

  assign unused_p_msb = p_reg[WIDTH];

  sub_borrow #(
    .WIDTH (WIDTH + 1)
  ) u_sub (
    .a         (trial),
    .b         ({1'b0, d_reg}),
    .diff      (diff),
    .no_borrow (no_borrow)
  );

  // Shift in the next dividend bit and keep the difference only if it did not borrow.
  always_comb begin
    trial  = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    p_next = no_borrow ? diff : trial;
    q_next = {q_reg[WIDTH-2:0], no_borrow};
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= StIdle;
      d_reg           <= '0;
      q_reg           <= '0;
      p_reg           <= '0;
      count           <= '0;
      dz_pend         <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        StIdle, StDone: begin
          if (dz_pend) begin
            // q_reg still holds the untouched dividend.
            bus.quotient    <= '1;
            bus.remainder   <= q_reg;
            bus.div_by_zero <= 1'b1;
            bus.done        <= 1'b1;
            dz_pend         <= 1'b0;
            state           <= StDone;
          end else if (bus.start) begin
            d_reg           <= bus.divisor;
            q_reg           <= bus.dividend;
            p_reg           <= '0;
            count           <= '0;
            bus.div_by_zero <= 1'b0;
            if (bus.divisor == '0) begin
              dz_pend <= 1'b1;
              state   <= StDone;
            end else begin
              bus.busy <= 1'b1;
              state    <= StRun;
            end
          end else begin
            state <= StIdle;
          end
        end
        StRun: begin
          p_reg <= p_next;
          q_reg <= q_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            bus.quotient  <= q_next;
            bus.remainder <= p_next[WIDTH-1:0];
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            state         <= StDone;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_div4_seq.sv
// Directed bench for the sequential divider.
module tb_div4_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   failed = 0;

  div4_seq_if #(.WIDTH(4)) bus ();

  div4_seq #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Start an op at a negedge; returns the edge index (0 = accept edge) where done was seen.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        output int done_edge, output int busy_cnt);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    done_edge    = -1;
    busy_cnt     = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_edge = e;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== 11'd0) begin
      failed++;
      $display("FAIL reset_outputs: got %b, expected 0",
               {bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int de, bc;
    run_op(4'd13, 4'd3, de, bc);
    tests++;
    if (de !== 4) begin failed++; $display("FAIL basic_latency: got %0d, expected 4", de); end
    tests++;
    if (bc !== 4) begin failed++; $display("FAIL basic_busy: got %0d, expected 4", bc); end
    tests++;
    if (bus.quotient !== 4'd4 || bus.remainder !== 4'd1 || bus.div_by_zero !== 1'b0) begin
      failed++;
      $display("FAIL basic_13_3: got q=%0d r=%0d z=%0d, expected q=4 r=1 z=0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.done !== 1'b0) begin failed++; $display("FAIL done_pulse: got %b, expected 0", bus.done); end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bus.quotient !== 4'd4 || bus.remainder !== 4'd1) begin
      failed++;
      $display("FAIL hold: got q=%0d r=%0d, expected q=4 r=1", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_vectors;
    int tv[3][4] = '{'{15, 1, 15, 0}, '{5, 7, 0, 5}, '{0, 9, 0, 0}};
    int de, bc;
    for (int i = 0; i < 3; i++) begin
      run_op(4'(tv[i][0]), 4'(tv[i][1]), de, bc);
      tests++;
      if (de !== 4 || bus.quotient !== 4'(tv[i][2]) || bus.remainder !== 4'(tv[i][3])) begin
        failed++;
        $display("FAIL vec_%0d_%0d: got edge=%0d q=%0d r=%0d, expected edge=4 q=%0d r=%0d",
                 tv[i][0], tv[i][1], de, bus.quotient, bus.remainder, tv[i][2], tv[i][3]);
      end
    end
  endtask

  task automatic test_div_zero;
    int de, bc;
    run_op(4'd9, 4'd0, de, bc);
    tests++;
    if (de !== 1 || bc !== 0) begin
      failed++;
      $display("FAIL dz_timing: got edge=%0d busy=%0d, expected edge=1 busy=0", de, bc);
    end
    tests++;
    if (bus.quotient !== 4'd15 || bus.remainder !== 4'd9 || bus.div_by_zero !== 1'b1) begin
      failed++;
      $display("FAIL dz_result: got q=%0d r=%0d z=%0d, expected q=15 r=9 z=1",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    run_op(4'd8, 4'd2, de, bc);
    tests++;
    if (bus.quotient !== 4'd4 || bus.remainder !== 4'd0 || bus.div_by_zero !== 1'b0) begin
      failed++;
      $display("FAIL dz_clear: got q=%0d r=%0d z=%0d, expected q=4 r=0 z=0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask

  task automatic test_busy_ignore;
    int dones = 0;
    int first = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd12; bus.divisor = 4'd5;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) bus.start = 1'b0;
      if (e == 1) begin bus.start = 1'b1; bus.dividend = 4'd7; bus.divisor = 4'd7; end
      if (e == 2) bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        if (first < 0) first = e;
      end
      if (e == 4) begin
        tests++;
        if (bus.quotient !== 4'd2 || bus.remainder !== 4'd2) begin
          failed++;
          $display("FAIL busy_ignore: got q=%0d r=%0d, expected q=2 r=2",
                   bus.quotient, bus.remainder);
        end
      end
    end
    tests++;
    if (dones !== 1 || first !== 4) begin
      failed++;
      $display("FAIL busy_done_count: got %0d at edge %0d, expected 1 at edge 4", dones, first);
    end
  endtask

  task automatic test_reset_mid;
    int de, bc;
    int dones = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd4;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== 11'd0) begin
      failed++;
      $display("FAIL mid_reset: got %b, expected 0",
               {bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    tests++;
    if (dones !== 0) begin failed++; $display("FAIL mid_no_done: got %0d, expected 0", dones); end
    run_op(4'd14, 4'd4, de, bc);
    tests++;
    if (de !== 4 || bus.quotient !== 4'd3 || bus.remainder !== 4'd2) begin
      failed++;
      $display("FAIL after_reset: got edge=%0d q=%0d r=%0d, expected edge=4 q=3 r=2",
               de, bus.quotient, bus.remainder);
    end
  endtask

  // All 256 pairs, each next start raised in the DONE cycle of the previous op.
  task automatic test_back_to_back;
    logic [3:0] a, b, eq, er;
    logic       ez, got;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd0; bus.divisor = 4'd0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) begin
      a = 4'(i >> 4);
      b = 4'(i);
      tests++;
      if (bus.busy !== (b != 4'd0) || bus.done !== 1'b0) begin
        failed++;
        $display("FAIL b2b_accept_%0d_%0d: got busy=%b done=%b, expected busy=%b done=0",
                 a, b, bus.busy, bus.done, (b != 4'd0));
      end
      bus.start = 1'b0;
      got = 1'b0;
      for (int e = 0; e < 10 && !got; e++) begin
        @(posedge clk);
        #1;
        if (bus.done) got = 1'b1;
      end
      if (b == 4'd0) begin eq = 4'd15; er = a; ez = 1'b1; end
      else begin eq = a / b; er = a % b; ez = 1'b0; end
      tests++;
      if (!got || bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== ez) begin
        failed++;
        $display("FAIL sweep_%0d_%0d: got done=%b q=%0d r=%0d z=%b, expected q=%0d r=%0d z=%b",
                 a, b, got, bus.quotient, bus.remainder, bus.div_by_zero, eq, er, ez);
      end
      if (got && !bus.div_by_zero) begin
        tests++;
        if (int'(bus.quotient) * int'(b) + int'(bus.remainder) != int'(a) ||
            bus.remainder >= b) begin
          failed++;
          $display("FAIL invariant_%0d_%0d: got q=%0d r=%0d", a, b, bus.quotient, bus.remainder);
        end
      end
      if (i < 255) begin
        bus.start    = 1'b1;
        bus.dividend = 4'((i + 1) >> 4);
        bus.divisor  = 4'(i + 1);
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = 4'd0;
    bus.divisor  = 4'd0;
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
